// File: rtl/data_mem_responder_if.sv
// Load/store handshake between the CPU MEM stage (master) and the
// multi-cycle data-memory responder (slave).
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage of the 5-stage CPU.
// One access is in flight at a time: IDLE accepts, WAIT burns LATENCY
// cycles, RESP pulses resp_valid for one cycle. stall freezes the upstream
// stages while a request is outstanding.
// Optional build macro MISALIGN_ERR_EN: misaligned requests bypass WAIT and
// complete on the next edge with resp_err = 1 and no memory write. Without
// it the low two address bits are ignored and resp_err stays 0.
module data_mem_responder #(
  parameter int    DEPTH_WORDS = 256,
  parameter int    LATENCY     = 2,
  parameter string MEMFILE     = "Memory.txt"
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              write_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [31:0]       resp_rdata_q;
  logic [31:0]       mem [DEPTH_WORDS];
  logic              misalign;
  logic              access_now;
  logic              unused_addr;

`ifdef MISALIGN_ERR_EN
  assign misalign = (bus.req_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Upper address bits wrap away; byte-offset bits only matter for the check.
  assign unused_addr = ^{bus.req_addr[31:ADDR_W+2], bus.req_addr[1:0]};

  // The access edge is the last WAIT cycle with the countdown exhausted.
  assign access_now = (state == WAIT) && (cnt == 4'd0);

  assign bus.req_ready  = (state == IDLE);
  assign bus.stall      = bus.req_valid & ~resp_valid_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

  // Store port: kept out of the reset domain so the array is never cleared;
  // an async reset drops state out of WAIT and so cancels a pending write.
  always_ff @(posedge clk) begin
    if (access_now && write_q) mem[addr_q] <= wdata_q;
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      write_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q  <= bus.req_addr[ADDR_W+1:2];
            wdata_q <= bus.req_wdata;
            write_q <= bus.req_write;
            if (misalign) begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'h0;
            end else begin
              cnt   <= 4'(LATENCY - 1);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= write_q ? 32'h0 : mem[addr_q];
          end
        end
        RESP: begin
          state        <= IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (DEPTH_WORDS=256, LATENCY=2).
// Expected responses come from a small word-memory model and are queued
// when a request is driven, then popped when resp_valid appears.
`define CHECK(TAG, OBS, EXP) \
  begin \
    n_tests++; \
    assert ((OBS) === (EXP)) else begin \
      n_fail++; \
      $error("FAIL %s: observed %0h, expected %0h", TAG, (OBS), (EXP)); \
    end \
  end

module tb_data_mem_responder;
  localparam int LAT = 2;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] model_mem [256];
  logic [32:0] sb [$];

  data_mem_responder_if bus ();

  data_mem_responder #(
    .DEPTH_WORDS(256),
    .LATENCY    (LAT),
    .MEMFILE    ("")
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one request at a negedge and follow it to its response. When
  // perturb is set, the request lines are changed and dropped in cycle 1.
  // Returns at the negedge of the IDLE cycle after RESP with req_valid
  // still as driven, so a chained call models a request held through RESP.
  task automatic access(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input bit perturb);
    int          idx;
    int          cyc;
    int          exp_lat;
    bit          got;
    bit          mis;
    logic [32:0] exp_v;
    logic [32:0] act_v;
    idx = int'((a >> 2) & 32'hFF);
    mis = 1'b0;
`ifdef MISALIGN_ERR_EN
    mis = (a[1:0] != 2'b00);
`endif
    if (mis) begin
      exp_v   = {1'b1, 32'h0};
      exp_lat = 1;
    end else if (w) begin
      exp_v          = {1'b0, 32'h0};
      model_mem[idx] = d;
      exp_lat        = LAT + 1;
    end else begin
      exp_v   = {1'b0, model_mem[idx]};
      exp_lat = LAT + 1;
    end
    sb.push_back(exp_v);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      if (perturb && cyc == 1) begin
        bus.req_addr  = 32'h20;
        bus.req_valid = 1'b0;
        bus.req_write = ~w;
        bus.req_wdata = 32'hFFFF_FFFF;
      end
      #1;
      if (bus.resp_valid === 1'b1) begin
        got = 1'b1;
        `CHECK("latency", cyc, exp_lat)
        `CHECK("stall_at_resp", bus.stall, 1'b0)
        `CHECK("ready_in_resp", bus.req_ready, 1'b0)
        act_v = {bus.resp_err, bus.resp_rdata};
        exp_v = sb.pop_front();
        `CHECK("resp_err_rdata", act_v, exp_v)
      end else begin
        `CHECK("stall_busy", bus.stall, bus.req_valid)
        `CHECK("ready_busy", bus.req_ready, (cyc == 0))
      end
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $error("FAIL resp_timeout: no resp_valid within %0d cycles for addr %0h",
             cyc, a);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    #1;
    `CHECK("ready_after_resp", bus.req_ready, 1'b1)
    `CHECK("valid_after_resp", bus.resp_valid, 1'b0)
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;

    // Reset state while held in reset with clocks running.
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 ||
        bus.stall !== 1'b0 || bus.resp_rdata !== 32'h0 ||
        bus.resp_err !== 1'b0) begin
      n_fail++;
      $error("FAIL reset_state: ready=%b valid=%b stall=%b rdata=%0h err=%b",
             bus.req_ready, bus.resp_valid, bus.stall, bus.resp_rdata,
             bus.resp_err);
    end
    `CHECK("rst_ready", bus.req_ready, 1'b1)
    `CHECK("rst_resp_valid", bus.resp_valid, 1'b0)
    `CHECK("rst_stall", bus.stall, 1'b0)
    `CHECK("rst_rdata", bus.resp_rdata, 32'h0)
    `CHECK("rst_err", bus.resp_err, 1'b0)
    rst_n = 1'b1;
    @(negedge clk);

    // Store then load at 0x10.
    access(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    access(1'b0, 32'h10, 32'h0, 1'b0);

    // rdata holds after the pulse; async reset clears it between edges.
    bus.req_valid = 1'b0;
    #2;
    `CHECK("rdata_hold", bus.resp_rdata, 32'hDEAD_BEEF)
    rst_n = 1'b0;
    #1;
    `CHECK("async_rst_rdata", bus.resp_rdata, 32'h0)
    `CHECK("async_rst_ready", bus.req_ready, 1'b1)
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Address wrap: 0x400 aliases word 0.
    access(1'b1, 32'h400, 32'hA5A5_A5A5, 1'b0);
    access(1'b0, 32'h000, 32'h0, 1'b0);

    // Request lines changed and dropped during WAIT are ignored.
    access(1'b1, 32'h20, 32'h1234_5678, 1'b0);
    access(1'b0, 32'h10, 32'h0, 1'b1);

    // Request held through RESP is taken only in the following IDLE cycle.
    access(1'b0, 32'h20, 32'h0, 1'b0);
    access(1'b0, 32'h400, 32'h0, 1'b0);

    // Reset during WAIT aborts a store to 0x08.
    access(1'b1, 32'h08, 32'h1111_2222, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h08;
    bus.req_wdata = 32'h0000_0055;
    @(negedge clk);
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    `CHECK("midwait_rst_ready", bus.req_ready, 1'b1)
    `CHECK("midwait_rst_valid", bus.resp_valid, 1'b0)
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      `CHECK("no_resp_after_abort", bus.resp_valid, 1'b0)
    end
    access(1'b0, 32'h08, 32'h0, 1'b0);

    // Misaligned store into word 3, then read word 3 back.
    access(1'b1, 32'h0C, 32'h3333_4444, 1'b0);
    access(1'b1, 32'h0E, 32'hCAFE_F00D, 1'b0);
    access(1'b0, 32'h0C, 32'h0, 1'b0);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);

    `CHECK("scoreboard_empty", sb.size(), 0)
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
